// File: rtl/alu_ctrl_seq_if.sv
// Bundle of start/IR inputs and datapath control strobes between the
// register-to-register instruction sequencer and the CPU datapath.
interface alu_ctrl_seq_if #(
  parameter int NREG = 16,
  parameter int OPW  = 5
);
  logic            start;
  logic            mem_ready;
  logic [31:0]     ir;
  logic [NREG-1:0] Rin;
  logic [NREG-1:0] Rout;
  logic            PCout;
  logic            PCin;
  logic            IncPC;
  logic            MARin;
  logic            MDRread;
  logic            MDRin;
  logic            MDRout;
  logic            IRin;
  logic            Yin;
  logic            ZLOin;
  logic            ZHIin;
  logic            ZLOout;
  logic            ZHIout;
  logic            LOin;
  logic            HIin;
  logic [OPW-1:0]  op_code;
  logic            busy;
  logic            done;

  modport master (
    output start, mem_ready, ir,
    input  Rin, Rout, PCout, PCin, IncPC, MARin, MDRread, MDRin, MDRout,
           IRin, Yin, ZLOin, ZHIin, ZLOout, ZHIout, LOin, HIin,
           op_code, busy, done
  );

  modport slave (
    input  start, mem_ready, ir,
    output Rin, Rout, PCout, PCin, IncPC, MARin, MDRread, MDRin, MDRout,
           IRin, Yin, ZLOin, ZHIin, ZLOout, ZHIout, LOin, HIin,
           op_code, busy, done
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Control-step sequencer (T0..T6) for register-to-register ALU instructions.
// Define SEQ_MEMWAIT_EN to make the T1 fetch step wait for mem_ready.
module alu_ctrl_seq #(
  parameter int             NREG   = 16,
  parameter int             OPW    = 5,
  parameter logic [OPW-1:0] OP_MUL = 5'b01111,
  parameter logic [OPW-1:0] OP_DIV = 5'b10000
) (
  input logic          clk,
  input logic          reset,
  alu_ctrl_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6,
    T6   = 3'd7
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]     ra;
  logic [3:0]     rb;
  logic [3:0]     rc;
  logic [OPW-1:0] opc;
  logic           wide;

  assign ra   = bus.ir[26:23];
  assign rb   = bus.ir[22:19];
  assign rc   = bus.ir[18:15];
  assign opc  = bus.ir[31:32-OPW];
  assign wide = (opc == OP_MUL) || (opc == OP_DIV);

  // Indices beyond the register file simply select nothing.
  function automatic logic [NREG-1:0] reg_sel(input logic [3:0] idx);
    logic [NREG-1:0] r;
    r = '0;
    for (int i = 0; i < NREG; i++) begin
      r[i] = (int'(idx) == i);
    end
    return r;
  endfunction

`ifdef SEQ_MEMWAIT_EN
  logic fetch_ok;
  assign fetch_ok = bus.mem_ready;
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.ir[14:0]};
`else
  logic fetch_ok;
  assign fetch_ok = 1'b1;
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.mem_ready, bus.ir[14:0]};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs depend only on state and ir, so start never reaches them directly.
  always_comb begin
    state_next   = state;
    bus.Rin      = '0;
    bus.Rout     = '0;
    bus.PCout    = 1'b0;
    bus.PCin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.MARin    = 1'b0;
    bus.MDRread  = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.ZLOin    = 1'b0;
    bus.ZHIin    = 1'b0;
    bus.ZLOout   = 1'b0;
    bus.ZHIout   = 1'b0;
    bus.LOin     = 1'b0;
    bus.HIin     = 1'b0;
    bus.op_code  = '0;
    bus.busy     = (state != IDLE);
    bus.done     = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) state_next = T0;
      end
      T0: begin
        bus.PCout  = 1'b1;
        bus.MARin  = 1'b1;
        bus.IncPC  = 1'b1;
        bus.ZLOin  = 1'b1;
        state_next = T1;
      end
      T1: begin
        bus.ZLOout  = 1'b1;
        bus.PCin    = 1'b1;
        bus.MDRread = 1'b1;
        bus.MDRin   = 1'b1;
        if (fetch_ok) state_next = T2;
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_next = T3;
      end
      T3: begin
        bus.Rout   = reg_sel(rb);
        bus.Yin    = 1'b1;
        state_next = T4;
      end
      T4: begin
        bus.Rout    = reg_sel(rc);
        bus.op_code = opc;
        bus.ZLOin   = 1'b1;
        bus.ZHIin   = wide;
        state_next  = T5;
      end
      T5: begin
        bus.ZLOout = 1'b1;
        if (wide) begin
          bus.LOin   = 1'b1;
          state_next = T6;
        end else begin
          bus.Rin    = reg_sel(ra);
          bus.done   = 1'b1;
          state_next = bus.start ? T0 : IDLE;
        end
      end
      T6: begin
        bus.ZHIout = 1'b1;
        bus.HIin   = 1'b1;
        bus.done   = 1'b1;
        state_next = bus.start ? T0 : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Parametrised control-step sequencer for register-to-register ALU instructions in the CPU datapath. Replaces hand-driven T0–T5 strobes with a state machine that fetches the instruction, decodes the IR fields and drives the one-hot register enables, bus-out selects, ALU op code and Z/HI/LO strobes. Adds over the hand-sequenced flow:
- a configurable register-file size;
- a 64-bit result path that writes both Z halves into HI/LO for wide ops (mul/div);
- back-to-back issue;
- an optional memory-ready wait in the fetch step.

## Interface
- NREG, 16, number of general registers driven. Register index fields are 4 bits; index ≥ NREG produces no strobe.
- OPW, 5, op code width (IR[31:32-OPW]).
- OP_MUL, 5'b01111, op code treated as wide.
- OP_DIV, 5'b10000, op code treated as wide.

Ports:
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock; forces IDLE
- start  in  1  request to execute one instruction
- mem_ready  in  1  memory data valid (used only with SEQ_MEMWAIT_EN)
- ir  in  32  datapath IR output; fields ra=IR[26:23], rb=IR[22:19], rc=IR[18:15]
- Rin  out  NREG  one-hot register load enables
- Rout  out  NREG  one-hot register bus-out selects
- PCout, PCin, IncPC, MARin  out  1 each  PC/MAR controls
- MDRread, MDRin, MDRout, IRin, Yin  out  1 each  fetch/operand controls
- ZLOin, ZHIin, ZLOout, ZHIout, LOin, HIin  out  1 each  result controls
- op_code  out  OPW  ALU operation, 0 except in T4
- busy  out  1  high in T0–T6
- done  out  1  one-cycle pulse in final step

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6. Outputs are a pure decode of state plus `ir`; there are no combinational paths from `start` to outputs.
- IDLE: all outputs 0. `start`=1 → T0.
- T0: PCout, MARin, IncPC, ZLOin. → T1.
- T1: ZLOout, PCin, MDRread, MDRin. → T2.
- T2: MDRout, IRin. → T3.
- T3: Rout[rb], Yin. → T4.
- T4: Rout[rc], op_code=ir[31:32-OPW], ZLOin; ZHIin also asserted if wide. → T5.
- T5, normal op: ZLOout, Rin[ra], done. Next state is T0 if `start`=1, else IDLE.
- T5, wide op: ZLOout, LOin; no Rin. → T6.
- T6 (wide only): ZHIout, HIin, done. Next state is T0 if `start`=1, else IDLE.
- Wide is defined as opcode == OP_MUL or OP_DIV, decoded from `ir` in T4–T6. `ir` is stable from T3 because IRin pulses only in T2.
- `start` is sampled only in IDLE and in the done step. It is ignored elsewhere.
- At most one bit of Rin and at most one bit of Rout is set.
- Index ≥ NREG: the corresponding Rin/Rout is all-zero. The step still executes and the sequence continues.

## Timing
- Reset: every output is 0 and the state is IDLE after the edge on which `reset`=1. This holds mid-instruction: a partial instruction is abandoned with no further strobes.
- Latency, `start` edge to done:
  - normal op: 6 cycles (T0..T5);
  - wide op: 7 cycles (T0..T6);
  - plus T1 wait cycles when SEQ_MEMWAIT_EN is defined.
- `busy` rises in the cycle after `start` is sampled in IDLE.
- Back-to-back: with `start` held high, T0 immediately follows the done step, so `busy` stays high and there is no idle cycle.
- `reset` and `start` asserted together: reset wins.

## Configuration
- SEQ_MEMWAIT_EN defined:
  - T1 advances only on a cycle where `mem_ready`=1.
  - While waiting, all T1 outputs are held and MDRin stays high.
  - `reset` during the wait returns to IDLE.
- SEQ_MEMWAIT_EN undefined: `mem_ready` is ignored and T1 lasts exactly one cycle.

## Test plan
- **shr r1,r3,r5:** ir=32'h389A8000, one `start` pulse.
  - T3 asserts Rout=16'h0008 with Yin.
  - T4 asserts Rout=16'h0020 with op_code=5'b00111 and ZLOin.
  - T5 asserts Rin=16'h0002 with ZLOout and done.
  - Then IDLE; done is exactly one pulse, 6 cycles after start.
- **Wide op (mul):** ir with opcode 5'b01111, rb=2, rc=4.
  - T4 asserts ZLOin and ZHIin together.
  - T5 asserts LOin with Rin=0.
  - T6 asserts HIin, ZHIout and done; 7 cycles total.
- **Back-to-back:** `start` held high for two instructions → second T0 immediately follows the first done step; `busy` never drops; done pulses twice.
- **Reset during T4:** all outputs 0 on the next cycle, state IDLE, no Rin pulse. A following `start` runs a clean 6-cycle sequence.
- **NREG=8, ra=4'd12:** T5 asserts ZLOout and done with Rin=0; no out-of-range strobe.
- **SEQ_MEMWAIT_EN, `mem_ready` low for 3 cycles:** T1 outputs are held 4 cycles; done arrives at cycle 9.
